// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen bus bridges.
// Holds the response status codes and the APB bridge state encoding.
package rggen_rtl_pkg;

  localparam logic [1:0] RGGEN_OKAY         = 2'b00;
  localparam logic [1:0] RGGEN_EXOKAY       = 2'b01;
  localparam logic [1:0] RGGEN_SLAVE_ERROR  = 2'b10;
  localparam logic [1:0] RGGEN_DECODE_ERROR = 2'b11;

  typedef enum logic [1:0] {
    APB_IDLE     = 2'b00,
    APB_SETUP    = 2'b01,
    APB_ACCESS   = 2'b10,
    APB_RESPONSE = 2'b11
  } apb_state_e;

endpackage

// File: rtl/rggen_apb_bridge.sv
// Command-to-APB bridge: one outstanding transfer,
// optional ACCESS timeout reported as a decode error.
module rggen_apb_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int         ADDRESS_WIDTH = 16,
  parameter int         DATA_WIDTH    = 32,
  parameter int         TIMEOUT       = 0,
  parameter logic [2:0] PPROT         = 3'b000
)(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_command_valid,
  input  logic                       i_write,
  input  logic                       i_read,
  input  logic [ADDRESS_WIDTH-1:0]   i_address,
  input  logic [DATA_WIDTH-1:0]      i_write_data,
  input  logic [DATA_WIDTH-1:0]      i_write_mask,
  output logic                       o_response_ready,
  output logic [DATA_WIDTH-1:0]      o_read_data,
  output logic [1:0]                 o_status,
  output logic [ADDRESS_WIDTH-1:0]   o_paddr,
  output logic [2:0]                 o_pprot,
  output logic                       o_psel,
  output logic                       o_penable,
  output logic                       o_pwrite,
  output logic [DATA_WIDTH-1:0]      o_pwdata,
  output logic [DATA_WIDTH/8-1:0]    o_pstrb,
  input  logic                       i_pready,
  input  logic [DATA_WIDTH-1:0]      i_prdata,
  input  logic                       i_pslverr
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LSB   = $clog2(BYTES);
  localparam int CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [ADDRESS_WIDTH-1:0] ALIGN =
    ~ADDRESS_WIDTH'((1 << LSB) - 1);
  localparam logic [CW-1:0] LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic TMO_EN = (TIMEOUT > 0);

  apb_state_e      state;
  logic [CW-1:0]   count;
  logic [BYTES-1:0] strb;
  logic            timed_out;

  for (genvar i = 0; i < BYTES; i++) begin : g_strb
    assign strb[i] = |i_write_mask[8*i+:8];
  end

  // i_pready in the final counted cycle still completes normally
  assign timed_out = TMO_EN && (count == LAST) && !i_pready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= APB_IDLE;
      count       <= '0;
      o_paddr     <= '0;
      o_pwrite    <= 1'b0;
      o_pwdata    <= '0;
      o_pstrb     <= '0;
      o_read_data <= '0;
      o_status    <= RGGEN_OKAY;
    end else begin
      unique case (state)
        APB_IDLE: begin
          if (i_command_valid) begin
            if (i_write || i_read) begin
              state    <= APB_SETUP;
              o_paddr  <= i_address & ALIGN;
              o_pwrite <= i_write;
              o_pwdata <= i_write_data;
              o_pstrb  <= i_write ? strb : '0;
            end else begin
              state       <= APB_RESPONSE;
              o_read_data <= '0;
              o_status    <= RGGEN_DECODE_ERROR;
            end
          end
        end
        APB_SETUP: begin
          state <= APB_ACCESS;
        end
        APB_ACCESS: begin
          if (i_pready) begin
            state       <= APB_RESPONSE;
            count       <= '0;
            o_read_data <= o_pwrite ? '0 : i_prdata;
            o_status    <= i_pslverr ? RGGEN_SLAVE_ERROR
                                     : RGGEN_OKAY;
          end else if (timed_out) begin
            state       <= APB_RESPONSE;
            count       <= '0;
            o_read_data <= '0;
            o_status    <= RGGEN_DECODE_ERROR;
          end else if (TMO_EN) begin
            count <= count + CW'(1);
          end
        end
        APB_RESPONSE: begin
          state <= APB_IDLE;
        end
        default: begin
          state <= APB_IDLE;
        end
      endcase
    end
  end

  assign o_psel           = (state == APB_SETUP) ||
                            (state == APB_ACCESS);
  assign o_penable        = (state == APB_ACCESS);
  assign o_response_ready = (state == APB_RESPONSE);
  assign o_pprot          = PPROT;

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// Table-driven bench for rggen_apb_bridge with a
// scoreboard queue and an APB slave with wait states.
module tb_rggen_apb_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_command_valid = 1'b0;
  logic        i_write = 1'b0;
  logic        i_read = 1'b0;
  logic [15:0] i_address = '0;
  logic [31:0] i_write_data = '0;
  logic [31:0] i_write_mask = '0;
  logic        o_response_ready;
  logic [31:0] o_read_data;
  logic [1:0]  o_status;
  logic [15:0] o_paddr;
  logic [2:0]  o_pprot;
  logic        o_psel;
  logic        o_penable;
  logic        o_pwrite;
  logic [31:0] o_pwdata;
  logic [3:0]  o_pstrb;
  logic        i_pready = 1'b0;
  logic [31:0] i_prdata = '0;
  logic        i_pslverr = 1'b0;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  rggen_apb_bridge #(
    .ADDRESS_WIDTH (16),
    .DATA_WIDTH    (32),
    .TIMEOUT       (4),
    .PPROT         (3'b010)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_command_valid  (i_command_valid),
    .i_write          (i_write),
    .i_read           (i_read),
    .i_address        (i_address),
    .i_write_data     (i_write_data),
    .i_write_mask     (i_write_mask),
    .o_response_ready (o_response_ready),
    .o_read_data      (o_read_data),
    .o_status         (o_status),
    .o_paddr          (o_paddr),
    .o_pprot          (o_pprot),
    .o_psel           (o_psel),
    .o_penable        (o_penable),
    .o_pwrite         (o_pwrite),
    .o_pwdata         (o_pwdata),
    .o_pstrb          (o_pstrb),
    .i_pready         (i_pready),
    .i_prdata         (i_prdata),
    .i_pslverr        (i_pslverr)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] mask;
    int          waits;
    logic [31:0] prdata;
    logic        slverr;
    logic [15:0] exp_paddr;
    logic [3:0]  exp_pstrb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_status;
    int          exp_access;
  } vec_t;

  vec_t vecs[9];
  vec_t sb[$];

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               name, act, exp);
    else
      n_pass++;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_psel"},   64'(o_psel), 64'd0);
    check({tag, "_pen"},    64'(o_penable), 64'd0);
    check({tag, "_pwrite"}, 64'(o_pwrite), 64'd0);
    check({tag, "_resp"},   64'(o_response_ready), 64'd0);
    check({tag, "_paddr"},  64'(o_paddr), 64'd0);
    check({tag, "_pwdata"}, 64'(o_pwdata), 64'd0);
    check({tag, "_pstrb"},  64'(o_pstrb), 64'd0);
    check({tag, "_rdata"},  64'(o_read_data), 64'd0);
    check({tag, "_status"}, 64'(o_status), 64'd0);
  endtask

  // Entered at a negedge with the DUT idle; leaves at the
  // negedge of the idle cycle after the response.
  task automatic run_vec(vec_t v, string tag);
    vec_t e;
    int   n;
    int   acc;
    int   setups;
    int   lat;
    bit   got;
    i_command_valid = 1'b1;
    i_write         = v.wr;
    i_read          = v.rd;
    i_address       = v.addr;
    i_write_data    = v.wdata;
    i_write_mask    = v.mask;
    sb.push_back(v);
    @(posedge clk);
    #1;
    i_command_valid = 1'b0;
    i_write         = 1'($urandom);
    i_read          = 1'($urandom);
    i_address       = 16'($urandom);
    i_write_data    = $urandom;
    i_write_mask    = $urandom;
    acc    = 0;
    setups = 0;
    lat    = 0;
    got    = 1'b0;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      i_pready  = 1'b0;
      i_pslverr = 1'b0;
      i_prdata  = 32'hBAD0_BAD0;
      if (o_response_ready) begin
        lat = n;
        got = 1'b1;
        break;
      end
      if (o_psel) begin
        check({tag, "_apb"},
              {40'd0, o_paddr, o_pstrb, o_pwrite, o_pprot},
              {40'd0, v.exp_paddr, v.exp_pstrb, v.wr, 3'b010});
        if (v.wr)
          check({tag, "_pwdata"}, 64'(o_pwdata), 64'(v.wdata));
        if (!o_penable) begin
          setups++;
          check({tag, "_setup_first"}, 64'(acc), 64'd0);
        end else begin
          acc++;
          if (acc > v.waits) begin
            i_pready  = 1'b1;
            i_pslverr = v.slverr;
            i_prdata  = v.prdata;
          end
        end
      end
    end
    if (!got) begin
      check({tag, "_no_response"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_latency"}, 64'(lat),
            64'(e.exp_access == 0 ? 1 : e.exp_access + 2));
      check({tag, "_access"}, 64'(acc), 64'(e.exp_access));
      check({tag, "_setups"}, 64'(setups),
            64'(e.exp_access == 0 ? 0 : 1));
      check({tag, "_rdata"}, 64'(o_read_data), 64'(e.exp_rdata));
      check({tag, "_status"}, 64'(o_status), 64'(e.exp_status));
      check({tag, "_resp_psel"}, 64'({o_psel, o_penable}), 64'd0);
      @(negedge clk);
      check({tag, "_pulse_one"}, 64'(o_response_ready), 64'd0);
      check({tag, "_idle_psel"}, 64'(o_psel), 64'd0);
      check({tag, "_hold"}, {30'd0, o_status, o_read_data},
            {30'd0, e.exp_status, e.exp_rdata});
    end
  endtask

  initial begin
    vecs[0] = '{1, 0, 16'h0006, 32'h0000_1234, 32'h0000_FFFF,
                0, 32'h0, 0, 16'h0004, 4'b0011,
                32'h0, 2'b00, 1};
    vecs[1] = '{0, 1, 16'h0010, 32'h0, 32'h0,
                2, 32'hDEAD_BEEF, 0, 16'h0010, 4'b0000,
                32'hDEAD_BEEF, 2'b00, 3};
    vecs[2] = '{0, 1, 16'h0022, 32'h0, 32'hFFFF_FFFF,
                0, 32'h0000_0055, 1, 16'h0020, 4'b0000,
                32'h0000_0055, 2'b10, 1};
    vecs[3] = '{0, 1, 16'h0030, 32'h0, 32'h0,
                99, 32'h1111_2222, 0, 16'h0030, 4'b0000,
                32'h0, 2'b11, 4};
    vecs[4] = '{0, 1, 16'h0041, 32'h0, 32'h0,
                3, 32'hCAFE_0001, 0, 16'h0040, 4'b0000,
                32'hCAFE_0001, 2'b00, 4};
    vecs[5] = '{1, 1, 16'h0103, 32'hAABB_CCDD, 32'hFF00_0000,
                1, 32'h9999_9999, 0, 16'h0100, 4'b1000,
                32'h0, 2'b00, 2};
    vecs[6] = '{0, 0, 16'h0200, 32'h0, 32'h0,
                0, 32'h0, 0, 16'h0, 4'b0000,
                32'h0, 2'b11, 0};
    vecs[7] = '{1, 0, 16'hFFFF, 32'h1357_9BDF, 32'h0100_8001,
                0, 32'h0, 1, 16'hFFFC, 4'b1011,
                32'h0, 2'b10, 1};
    vecs[8] = '{1, 0, 16'h0008, 32'h7777_7777, 32'h0,
                0, 32'h0, 0, 16'h0008, 4'b0000,
                32'h0, 2'b00, 1};

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_pprot", 64'(o_pprot), 64'h2);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++)
      run_vec(vecs[i], $sformatf("v%0d", i));

    run_vec(vecs[4], "pre_rst");
    i_command_valid = 1'b1;
    i_write         = 1'b0;
    i_read          = 1'b1;
    i_address       = 16'h0050;
    @(posedge clk);
    #1;
    i_command_valid = 1'b0;
    @(negedge clk);
    check("rst_setup", 64'({o_psel, o_penable}), 64'b10);
    @(negedge clk);
    check("rst_access", 64'({o_psel, o_penable}), 64'b11);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (o_response_ready || o_psel) seen++;
      end
      check("no_resp_after_rst", 64'(seen), 64'd0);
    end
    run_vec(vecs[0], "recover");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
